// File: rtl/stage_decode_hzd_pkg.sv
// Shared decode types, RV32I opcodes and immediate generation for the ID stage.
package stage_decode_hzd_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef struct packed {
    logic op;
    logic ld;
    logic st;
    logic jm;
    logic br;
    logic lui;
    logic auipc;
    logic reg_write;
  } ctrl_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // B and J targets are halfword aligned, so their bit 0 is always zero.
  function automatic logic signed [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic signed [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/stage_decode_hzd_regfile.sv
// Register file with two asynchronous read ports and one synchronous write port; x0 reads as zero.
module regfile_2r1w #(
  parameter  int NUM_REGS = 32,
  parameter  int XLEN     = 32,
  localparam int RIDX     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [RIDX-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RIDX-1:0] raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [RIDX-1:0] raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/stage_decode_hzd.sv
// RV32I decode stage: builds the ID/EX register, emits forwarding selects and stalls only on load-use.
module stage_decode_hzd
  import stage_decode_hzd_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_FWD  = 3,
  parameter  int CNT_W    = 16,
  localparam int RIDX     = $clog2(NUM_REGS),
  localparam int FSW      = $clog2(NUM_FWD + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [XLEN-1:0]              pc_i,
  input  logic [31:0]                  instr_i,
  input  logic                         instr_valid_i,
  output logic                         id_ready_o,
  input  logic                         flush_i,
  input  logic                         ex_ready_i,
  input  logic                         wb_we_i,
  input  logic [RIDX-1:0]              wb_rd_i,
  input  logic [XLEN-1:0]              wb_data_i,
  input  logic [NUM_FWD-1:0][RIDX-1:0] fwd_rd_i,
  input  logic [NUM_FWD-1:0]           fwd_we_i,
  input  logic [NUM_FWD-1:0]           fwd_pend_i,
  output logic                         valid_o,
  output logic [XLEN-1:0]              pc_o,
  output logic [6:0]                   opcode_o,
  output logic [2:0]                   funct3_o,
  output logic [6:0]                   funct7_o,
  output logic [RIDX-1:0]              rd_o,
  output logic [RIDX-1:0]              rs1_o,
  output logic [RIDX-1:0]              rs2_o,
  output logic [XLEN-1:0]              rs1_data_o,
  output logic [XLEN-1:0]              rs2_data_o,
  output logic [XLEN-1:0]              imm_o,
  output ctrl_t                        ctrl_o,
  output logic [FSW-1:0]               fwd_sel1_o,
  output logic [FSW-1:0]               fwd_sel2_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  logic [RIDX-1:0]        rd_d, rs1_d, rs2_d;
  logic [XLEN-1:0]        rf_rdata1, rf_rdata2, rs1_data_d, rs2_data_d;
  logic signed [XLEN-1:0] imm_d;
  ctrl_t                  ctrl_d;
  imm_fmt_e               fmt;
  logic                   use1, use2, pend1, pend2, hazard, load_en;
  logic [FSW-1:0]         sel1_d, sel2_d;

  logic                   valid_q;
  ctrl_t                  ctrl_q;
  logic [RIDX-1:0]        rd_q, rs1_q, rs2_q;
  logic [FSW-1:0]         sel1_q, sel2_q;
  logic [CNT_W-1:0]       stall_cnt_q;
  logic [XLEN-1:0]        pc_q, rs1_data_q, rs2_data_q;
  logic signed [XLEN-1:0] imm_q;
  logic [6:0]             opcode_q, funct7_q;
  logic [2:0]             funct3_q;

  assign rd_d  = instr_i[7 +: RIDX];
  assign rs1_d = instr_i[15 +: RIDX];
  assign rs2_d = instr_i[20 +: RIDX];

  always_comb begin
    ctrl_d = '0;
    fmt    = IMM_NONE;
    use1   = 1'b0;
    use2   = 1'b0;
    case (instr_i[6:0])
      OPCODE_OP:     begin ctrl_d.op    = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OPCODE_OP_IMM: begin ctrl_d.op    = 1'b1; use1 = 1'b1; fmt = IMM_I; end
      OPCODE_LOAD:   begin ctrl_d.ld    = 1'b1; use1 = 1'b1; fmt = IMM_I; end
      OPCODE_STORE:  begin ctrl_d.st    = 1'b1; use1 = 1'b1; use2 = 1'b1; fmt = IMM_S; end
      OPCODE_BRANCH: begin ctrl_d.br    = 1'b1; use1 = 1'b1; use2 = 1'b1; fmt = IMM_B; end
      OPCODE_JAL:    begin ctrl_d.jm    = 1'b1; fmt = IMM_J; end
      OPCODE_JALR:   begin ctrl_d.jm    = 1'b1; use1 = 1'b1; fmt = IMM_I; end
      OPCODE_LUI:    begin ctrl_d.lui   = 1'b1; fmt = IMM_U; end
      OPCODE_AUIPC:  begin ctrl_d.auipc = 1'b1; fmt = IMM_U; end
      default:       ;
    endcase
    ctrl_d.reg_write = (ctrl_d.op | ctrl_d.ld | ctrl_d.jm | ctrl_d.lui | ctrl_d.auipc) && rd_d != '0;
  end

  assign imm_d = XLEN'(imm_gen(instr_i, fmt));

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    sel1_d = '0;
    sel2_d = '0;
    pend1  = 1'b0;
    pend2  = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (rs1_d != '0 && fwd_we_i[k] && fwd_rd_i[k] == rs1_d) begin
        sel1_d = FSW'(k + 1);
        pend1  = fwd_pend_i[k];
      end
      if (rs2_d != '0 && fwd_we_i[k] && fwd_rd_i[k] == rs2_d) begin
        sel2_d = FSW'(k + 1);
        pend2  = fwd_pend_i[k];
      end
    end
  end

  assign hazard     = instr_valid_i && ((use1 && pend1) || (use2 && pend2));
  assign id_ready_o = ex_ready_i && !hazard;
  assign load_en    = ex_ready_i && !flush_i && !hazard;

  regfile_2r1w #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) u_rf (
    .clk      (clk),
    .we_i     (wb_we_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs1_d),
    .rdata1_o (rf_rdata1),
    .raddr2_i (rs2_d),
    .rdata2_o (rf_rdata2)
  );

  assign rs1_data_d = (wb_we_i && wb_rd_i == rs1_d && rs1_d != '0) ? wb_data_i : rf_rdata1;
  assign rs2_data_d = (wb_we_i && wb_rd_i == rs2_d && rs2_d != '0) ? wb_data_i : rf_rdata2;

  // ID/EX boundary: control state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      sel1_q      <= '0;
      sel2_q      <= '0;
      stall_cnt_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (ex_ready_i) begin
      if (hazard) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        if (stall_cnt_q != '1) begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
      end else begin
        valid_q <= instr_valid_i;
        ctrl_q  <= instr_valid_i ? ctrl_d : '0;
        rd_q    <= rd_d;
        sel1_q  <= sel1_d;
        sel2_q  <= sel2_d;
      end
    end
  end

  // ID/EX boundary: datapath
  always_ff @(posedge clk) begin
    if (load_en) begin
      pc_q       <= pc_i;
      opcode_q   <= instr_i[6:0];
      funct3_q   <= instr_i[14:12];
      funct7_q   <= instr_i[31:25];
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  assign valid_o     = valid_q;
  assign ctrl_o      = ctrl_q;
  assign rd_o        = rd_q;
  assign fwd_sel1_o  = sel1_q;
  assign fwd_sel2_o  = sel2_q;
  assign stall_cnt_o = stall_cnt_q;
  assign pc_o        = pc_q;
  assign opcode_o    = opcode_q;
  assign funct3_o    = funct3_q;
  assign funct7_o    = funct7_q;
  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;
  assign rs1_data_o  = rs1_data_q;
  assign rs2_data_o  = rs2_data_q;
  assign imm_o       = imm_q;

endmodule

// File: tb/tb_stage_decode_hzd.sv
// Bench for stage_decode_hzd: vector table, multi-cycle corner sequences and a random run against a reference model.
module tb_stage_decode_hzd;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [6:0] OP_R  = 7'h33, OP_I = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
  localparam logic [6:0] JAL   = 7'h6f, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [31:0]     pc = '0, instr = 32'h13;
  logic            ivalid = 1'b0, flush = 1'b0, exrdy = 1'b1;
  logic            wbwe = 1'b0;
  logic [4:0]      wbrd = '0;
  logic [31:0]     wbdata = '0;
  logic [2:0][4:0] frd = '0;
  logic [2:0]      fwe = '0, fpend = '0;

  logic            rdy, o_valid;
  logic [31:0]     o_pc, o_d1, o_d2, o_imm;
  logic [6:0]      o_opc, o_f7;
  logic [2:0]      o_f3;
  logic [4:0]      o_rd, o_rs1, o_rs2;
  logic [7:0]      o_ctrl;
  logic [1:0]      o_s1, o_s2;
  logic [CNT_W-1:0] o_cnt;

  always #5 clk = ~clk;

  stage_decode_hzd #(.XLEN(32), .NUM_REGS(32), .NUM_FWD(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .pc_i(pc), .instr_i(instr), .instr_valid_i(ivalid),
    .id_ready_o(rdy), .flush_i(flush), .ex_ready_i(exrdy), .wb_we_i(wbwe), .wb_rd_i(wbrd),
    .wb_data_i(wbdata), .fwd_rd_i(frd), .fwd_we_i(fwe), .fwd_pend_i(fpend),
    .valid_o(o_valid), .pc_o(o_pc), .opcode_o(o_opc), .funct3_o(o_f3), .funct7_o(o_f7),
    .rd_o(o_rd), .rs1_o(o_rs1), .rs2_o(o_rs2), .rs1_data_o(o_d1), .rs2_data_o(o_d2),
    .imm_o(o_imm), .ctrl_o(o_ctrl), .fwd_sel1_o(o_s1), .fwd_sel2_o(o_s2), .stall_cnt_o(o_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, rs1, rd);
    return {7'h00, rs2, rs1, 3'b000, rd, OP_R};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], ST};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], BR};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction

  // Reference model
  typedef struct {
    logic        valid, ctrl_zero, chk_imm;
    logic [31:0] pc, imm, d1, d2;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [7:0]  ctrl;
    logic [1:0]  s1, s2;
  } exp_t;

  exp_t        m;
  logic [31:0] mregs [32];
  int          mcnt = 0;
  logic        rdy_seen, rdy_model;

  // ctrl byte order {op,ld,st,jm,br,lui,auipc,reg_write}; fmt 0 none,1 I,2 S,3 B,4 U,5 J
  function automatic void m_class(input logic [6:0] opc, output logic [7:0] c,
                                  output logic u1, output logic u2, output int fmt);
    c = 8'h00; u1 = 1'b0; u2 = 1'b0; fmt = 0;
    case (opc)
      OP_R:    begin c = 8'h80; u1 = 1'b1; u2 = 1'b1; end
      OP_I:    begin c = 8'h80; u1 = 1'b1; fmt = 1; end
      LD:      begin c = 8'h40; u1 = 1'b1; fmt = 1; end
      ST:      begin c = 8'h20; u1 = 1'b1; u2 = 1'b1; fmt = 2; end
      BR:      begin c = 8'h08; u1 = 1'b1; u2 = 1'b1; fmt = 3; end
      JAL:     begin c = 8'h10; fmt = 5; end
      JALR:    begin c = 8'h10; u1 = 1'b1; fmt = 1; end
      LUI:     begin c = 8'h04; fmt = 4; end
      AUIPC:   begin c = 8'h02; fmt = 4; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] x, input int fmt);
    logic signed [31:0] v;
    case (fmt)
      1:       v = 32'($signed(x[31:20]));
      2:       v = 32'($signed({x[31:25], x[11:7]}));
      3:       v = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
      4:       v = {x[31:12], 12'h000};
      5:       v = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic void m_win(input logic [4:0] rs, output logic [1:0] sel, output logic pend);
    sel = 2'd0; pend = 1'b0;
    if (rs != 5'd0) begin
      for (int k = 0; k < 3; k++) begin
        if (fwe[k] && frd[k] == rs) begin
          sel = 2'(k + 1); pend = fpend[k];
          break;
        end
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (wbwe && wbrd == rs) return wbdata;
    return mregs[rs];
  endfunction

  task automatic m_step();
    logic [7:0] c;
    logic u1, u2, p1, p2, hz;
    logic [1:0] s1, s2;
    int fmt;
    m_class(instr[6:0], c, u1, u2, fmt);
    if ((c[7] | c[6] | c[4] | c[2] | c[1]) && instr[11:7] != 5'd0) c[0] = 1'b1;
    m_win(instr[19:15], s1, p1);
    m_win(instr[24:20], s2, p2);
    hz = ivalid && ((u1 && p1) || (u2 && p2));
    rdy_model = exrdy && !hz;
    if (!reset_n) begin
      m.valid = 1'b0; m.ctrl_zero = 1'b1; m.ctrl = '0; m.rd = '0; m.s1 = '0; m.s2 = '0; mcnt = 0;
    end else if (flush) begin
      m.valid = 1'b0; m.ctrl_zero = 1'b1; m.ctrl = '0;
    end else if (exrdy) begin
      if (hz) begin
        m.valid = 1'b0; m.ctrl_zero = 1'b1; m.ctrl = '0;
        if (mcnt < CNT_MAX) mcnt++;
      end else begin
        m.valid = ivalid; m.ctrl_zero = !ivalid; m.ctrl = c;
        m.pc = pc; m.opc = instr[6:0]; m.f3 = instr[14:12]; m.f7 = instr[31:25];
        m.rd = instr[11:7]; m.rs1 = instr[19:15]; m.rs2 = instr[24:20];
        m.d1 = m_read(instr[19:15]); m.d2 = m_read(instr[24:20]);
        m.imm = m_imm(instr, fmt); m.chk_imm = (fmt != 0);
        m.s1 = s1; m.s2 = s2;
      end
    end
    if (wbwe && wbrd != 5'd0) mregs[wbrd] = wbdata;
  endtask

  task automatic m_check();
    chk("rnd.valid", o_valid, m.valid);
    chk("rnd.cnt", o_cnt, mcnt);
    chk("rnd.ready", rdy_seen, rdy_model);
    if (m.valid) begin
      chk("rnd.ctrl", o_ctrl, m.ctrl);
      chk("rnd.pc", o_pc, m.pc);
      chk("rnd.fields", {o_opc, o_f3, o_f7, o_rd, o_rs1, o_rs2}, {m.opc, m.f3, m.f7, m.rd, m.rs1, m.rs2});
      chk("rnd.rsdata", {o_d1, o_d2}, {m.d1, m.d2});
      chk("rnd.sel", {o_s1, o_s2}, {m.s1, m.s2});
      if (m.chk_imm) chk("rnd.imm", o_imm, m.imm);
    end else if (m.ctrl_zero) begin
      chk("rnd.ctrl0", o_ctrl, 8'h00);
    end
  endtask

  // One clock: sample combinational ready, advance model, clock, settle.
  task automatic step();
    #1;
    rdy_seen = rdy;
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic [4:0] r0, r1, r2, input logic [2:0] we, pend);
    frd[0] = r0; frd[1] = r1; frd[2] = r2; fwe = we; fpend = pend;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  f0, f1, f2;
    logic [2:0]  we, pend;
    logic        rdy, vld;
    logic [7:0]  ctrl;
    logic [1:0]  s1, s2;
    logic        ci;
    logic [31:0] imm;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] r;
    vt[0]  = '{enc_r(5'd2, 5'd1, 5'd3),              5'd1, 5'd0, 5'd0, 3'b001, 3'b000, 1, 1, 8'h81, 2'd1, 2'd0, 0, 32'h0};
    vt[1]  = '{enc_r(5'd7, 5'd4, 5'd6),              5'd4, 5'd0, 5'd4, 3'b101, 3'b000, 1, 1, 8'h81, 2'd1, 2'd0, 0, 32'h0};
    vt[2]  = '{enc_r(5'd7, 5'd0, 5'd6),              5'd0, 5'd0, 5'd0, 3'b101, 3'b101, 1, 1, 8'h81, 2'd0, 2'd0, 0, 32'h0};
    vt[3]  = '{enc_r(5'd7, 5'd4, 5'd6),              5'd0, 5'd4, 5'd4, 3'b110, 3'b100, 1, 1, 8'h81, 2'd2, 2'd0, 0, 32'h0};
    vt[4]  = '{enc_i(32'd2, 5'd1, 3'd0, 5'd5, OP_I), 5'd2, 5'd0, 5'd0, 3'b001, 3'b001, 1, 1, 8'h81, 2'd0, 2'd1, 1, 32'd2};
    vt[5]  = '{enc_u(20'h12345, 5'd0, LUI),          5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 1, 1, 8'h04, 2'd0, 2'd0, 1, 32'h12345000};
    vt[6]  = '{enc_j(-32'sd4, 5'd1),                 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 1, 1, 8'h11, 2'd0, 2'd0, 1, 32'hFFFFFFFC};
    vt[7]  = '{enc_s(-32'sd8, 5'd2, 5'd3),           5'd0, 5'd3, 5'd0, 3'b010, 3'b000, 1, 1, 8'h20, 2'd2, 2'd0, 1, 32'hFFFFFFF8};
    vt[8]  = '{enc_b(32'd16, 5'd2, 5'd1),            5'd0, 5'd0, 5'd2, 3'b100, 3'b100, 0, 0, 8'h00, 2'd0, 2'd0, 0, 32'h0};
    vt[9]  = '{enc_i(32'd4, 5'd6, 3'd2, 5'd5, LD),   5'd6, 5'd0, 5'd0, 3'b001, 3'b001, 0, 0, 8'h00, 2'd0, 2'd0, 0, 32'h0};
    vt[10] = '{enc_u(20'hFFFFF, 5'd7, AUIPC),        5'd31, 5'd0, 5'd0, 3'b001, 3'b001, 1, 1, 8'h03, 2'd1, 2'd1, 1, 32'hFFFFF000};
    vt[11] = '{32'h000002FF,                         5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 1, 1, 8'h00, 2'd0, 2'd0, 0, 32'h0};

    // Reset must win over a loadable, forwarding instruction
    instr = enc_r(5'd2, 5'd1, 5'd3); ivalid = 1'b1; set_fwd(5'd1, 5'd2, 5'd0, 3'b011, 3'b000);
    step(); step();
    chk("reset.valid", o_valid, 1'b0);
    chk("reset.ctrl", o_ctrl, 8'h00);
    chk("reset.rd", o_rd, 5'd0);
    chk("reset.sel", {o_s1, o_s2}, 4'h0);
    chk("reset.cnt", o_cnt, 0);
    reset_n = 1'b1;

    // Fill the register file so every later read is defined
    ivalid = 1'b0; set_fwd(5'd0, 5'd0, 5'd0, 3'b000, 3'b000);
    for (int i = 1; i < 32; i++) begin
      wbwe = 1'b1; wbrd = 5'(i); r = $urandom(); wbdata = r;
      step();
    end
    wbwe = 1'b0;

    // Single-cycle decode/forwarding vectors
    for (int i = 0; i < 12; i++) begin
      pc = 32'h1000 + 32'(i * 4); instr = vt[i].instr; ivalid = 1'b1;
      set_fwd(vt[i].f0, vt[i].f1, vt[i].f2, vt[i].we, vt[i].pend);
      step();
      chk($sformatf("vec%0d.ready", i), rdy_seen, vt[i].rdy);
      chk($sformatf("vec%0d.valid", i), o_valid, vt[i].vld);
      chk($sformatf("vec%0d.ctrl", i), o_ctrl, vt[i].ctrl);
      if (vt[i].vld) begin
        chk($sformatf("vec%0d.sel", i), {o_s1, o_s2}, {vt[i].s1, vt[i].s2});
        chk($sformatf("vec%0d.pc", i), o_pc, pc);
        if (vt[i].ci) chk($sformatf("vec%0d.imm", i), o_imm, vt[i].imm);
      end
    end

    // Load-use: one bubble, then forward from MEM
    reset_n = 1'b0; ivalid = 1'b0; step(); reset_n = 1'b1;
    chk("lu.cnt0", o_cnt, 0);
    instr = enc_i(32'd0, 5'd1, 3'd2, 5'd5, LD); ivalid = 1'b1; set_fwd(5'd0, 5'd0, 5'd0, 3'b000, 3'b000);
    step();
    chk("lu.lw_valid", o_valid, 1'b1);
    chk("lu.lw_ctrl", o_ctrl, 8'h41);
    instr = enc_r(5'd7, 5'd5, 5'd6); set_fwd(5'd5, 5'd0, 5'd0, 3'b001, 3'b001);
    step();
    chk("lu.ready", rdy_seen, 1'b0);
    chk("lu.bubble_valid", o_valid, 1'b0);
    chk("lu.bubble_ctrl", o_ctrl, 8'h00);
    chk("lu.cnt1", o_cnt, 1);
    set_fwd(5'd0, 5'd5, 5'd0, 3'b010, 3'b000);
    step();
    chk("lu.ready2", rdy_seen, 1'b1);
    chk("lu.valid2", o_valid, 1'b1);
    chk("lu.sel", {o_s1, o_s2}, {2'd2, 2'd0});
    chk("lu.cnt_hold", o_cnt, 1);

    // WB bypass and x0 write suppression
    set_fwd(5'd0, 5'd0, 5'd0, 3'b000, 3'b000);
    wbwe = 1'b1; wbrd = 5'd9; wbdata = 32'hDEADBEEF; instr = enc_r(5'd0, 5'd9, 5'd1);
    step();
    chk("wb.bypass", o_d1, 32'hDEADBEEF);
    wbrd = 5'd0; wbdata = 32'h123; instr = enc_r(5'd9, 5'd0, 5'd1);
    step();
    chk("wb.stored", o_d2, 32'hDEADBEEF);
    chk("wb.x0_nobypass", o_d1, 32'h0);
    wbwe = 1'b0; instr = enc_r(5'd0, 5'd0, 5'd2);
    step();
    chk("wb.x0_read", o_d1, 32'h0);

    // Backpressure hold, then flush during the hold
    pc = 32'h200; instr = enc_i(32'd2, 5'd1, 3'd0, 5'd5, OP_I);
    step();
    chk("hold.load", o_valid, 1'b1);
    exrdy = 1'b0; pc = 32'h300; instr = enc_s(-32'sd8, 5'd2, 5'd3); set_fwd(5'd3, 5'd0, 5'd0, 3'b001, 3'b001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d.ready", i), rdy_seen, 1'b0);
      chk($sformatf("hold%0d.out", i), {o_valid, o_pc, o_imm, o_rd, o_ctrl},
          {1'b1, 32'h200, 32'd2, 5'd5, 8'h81});
      chk($sformatf("hold%0d.cnt", i), o_cnt, 1);
    end
    flush = 1'b1;
    step();
    chk("hold.flush_valid", o_valid, 1'b0);
    chk("hold.flush_ctrl", o_ctrl, 8'h00);

    // Flush outranks a load-use bubble
    exrdy = 1'b1; instr = enc_r(5'd7, 5'd5, 5'd6); set_fwd(5'd5, 5'd0, 5'd0, 3'b001, 3'b001);
    step();
    chk("flush_hz.ready", rdy_seen, 1'b0);
    chk("flush_hz.valid", o_valid, 1'b0);
    chk("flush_hz.cnt", o_cnt, 1);
    flush = 1'b0;

    // Counter saturation
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 13) chk("sat.cnt14", o_cnt, 14);
      if (i == 20) chk("sat.cnt_max", o_cnt, CNT_MAX);
    end

    // Randomized run against the model
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic [6:0] ops [9];
      ops = '{OP_R, OP_I, LD, ST, BR, JAL, JALR, LUI, AUIPC};
      r = $urandom(); instr = {r[31:25], r[24:20] & 5'h7, r[19:15] & 5'h7, r[14:7], ops[$urandom_range(0, 8)]};
      r = $urandom(); pc = {r[31:2], 2'b00};
      ivalid = ($urandom_range(0, 7) != 0);
      exrdy  = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 15) == 0);
      set_fwd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
      wbwe = $urandom_range(0, 1) != 0; wbrd = 5'($urandom_range(0, 7)); wbdata = $urandom();
      step();
      m_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
